spi_reg_writer: RTL and testbench

- Upstream stage of the signal generator: receives 8-bit register-write frames over a mode-0 SPI link and replays each one as an address/data/write-strobe transaction.
- The signal generator runs on the divided clock, so every strobe is stretched and framed by setup/recover gaps, all counted in fast-clock cycles.
- Frames received while a transaction is in flight are buffered in a small FIFO.

---
 rtl/spi_reg_writer_if.sv | 10 +
 rtl/spi_reg_writer.sv | 211 +++++++++++++++++++++
 tb/tb_spi_reg_writer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_writer_if.sv
// Register-write bus from spi_reg_writer to the signal generator.
// The writer drives the master side; the register file sits on the slave side.
interface spi_reg_writer_if;
  logic       wr_strobe;
  logic [2:0] wr_address;
  logic [4:0] wr_data;

  modport master (output wr_strobe, output wr_address, output wr_data);
  modport slave  (input  wr_strobe, input  wr_address, input  wr_data);
endinterface

// File: rtl/spi_reg_writer.sv
// Mode-0 SPI receiver that buffers 8-bit register-write frames and replays each
// one as an address/data/strobe transaction framed by setup, hold and recovery gaps.
module spi_reg_writer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYCLES = 8,
  parameter int HOLD_CYCLES  = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spi_sclk,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  input  logic             err_clr,
  spi_reg_writer_if.master wr_bus,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int MAX_CYC = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] SETUP_LOAD = TMR_W'(SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD  = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_ZERO   = TMR_W'(0);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  logic [2:0]       sclk_sync_q, sclk_sync_d;
  logic [1:0]       cs_sync_q, cs_sync_d;
  logic [1:0]       mosi_sync_q, mosi_sync_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [6:0]       shift_q, shift_d;
  logic [7:0]       fifo_q [FIFO_DEPTH];
  logic [7:0]       fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             strobe_q, strobe_d;
  logic [2:0]       addr_q, addr_d;
  logic [4:0]       data_q, data_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;

  logic             sclk_rise, push, pop, push_ok, ovr_set, ferr_set;
  logic [7:0]       rx_byte, head;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], spi_sclk};
    cs_sync_d   = {cs_sync_q[0], spi_cs_n};
    mosi_sync_d = {mosi_sync_q[0], spi_mosi};
    sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
    rx_byte     = {shift_q, mosi_sync_q[1]};

    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push      = 1'b0;
    ferr_set  = 1'b0;
    if (!ena) begin
      bit_cnt_d = 3'd0;
    end else if (cs_sync_q[1]) begin
      // A deselect mid-byte drops the partial byte.
      bit_cnt_d = 3'd0;
      ferr_set  = (bit_cnt_q != 3'd0);
    end else if (sclk_rise) begin
      shift_d   = rx_byte[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      push      = (bit_cnt_q == 3'd7);
    end else begin
      bit_cnt_d = bit_cnt_q;
    end

    head    = fifo_q[rd_ptr_q];
    pop     = (state_q == ST_IDLE) && (count_q != CNT_ZERO);
    push_ok = push && ((count_q != CNT_FULL) || pop);
    ovr_set = push && (count_q == CNT_FULL) && !pop;

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      fifo_d[wr_ptr_q] = rx_byte;
      wr_ptr_d         = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Set conditions dominate a coincident clear.
    overrun_d   = ovr_set  | (overrun_q   & ~err_clr);
    frame_err_d = ferr_set | (frame_err_q & ~err_clr);

    state_d  = state_q;
    tmr_d    = tmr_q;
    strobe_d = strobe_q;
    addr_d   = addr_q;
    data_d   = data_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          addr_d  = head[7:5];
          data_d  = head[4:0];
          tmr_d   = SETUP_LOAD;
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (tmr_q == TMR_ZERO) begin
          tmr_d    = HOLD_LOAD;
          strobe_d = 1'b1;
          state_d  = ST_STROBE;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      ST_STROBE: begin
        if (tmr_q == TMR_ZERO) begin
          tmr_d    = HOLD_LOAD;
          strobe_d = 1'b0;
          state_d  = ST_RECOVER;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      ST_RECOVER: begin
        if (tmr_q == TMR_ZERO) begin
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        strobe_d = 1'b0;
        tmr_d    = TMR_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= 8'd0;
      end
      rd_ptr_q    <= {PTR_W{1'b0}};
      wr_ptr_q    <= {PTR_W{1'b0}};
      count_q     <= CNT_ZERO;
      state_q     <= ST_IDLE;
      tmr_q       <= TMR_ZERO;
      strobe_q    <= 1'b0;
      addr_q      <= 3'd0;
      data_q      <= 5'd0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      fifo_q      <= fifo_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      strobe_q    <= strobe_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign wr_bus.wr_strobe  = strobe_q;
  assign wr_bus.wr_address = addr_q;
  assign wr_bus.wr_data    = data_q;
  assign busy              = (state_q != ST_IDLE) || (count_q != CNT_ZERO);
  assign overrun           = overrun_q;
  assign frame_err         = frame_err_q;
endmodule

// File: tb/tb_spi_reg_writer.sv
// Directed bench for spi_reg_writer: a transaction-level model predicts every
// output each cycle, and hand-computed literals pin the key timings and values.
`timescale 1ns/1ps
module tb_spi_reg_writer;
  localparam int S = 8;
  localparam int H = 128;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic spi_sclk = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic err_clr = 1'b0;
  logic busy, overrun, frame_err;

  spi_reg_writer_if bus ();

  spi_reg_writer #(.FIFO_DEPTH(D), .SETUP_CYCLES(S), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .err_clr(err_clr), .wr_bus(bus.master), .busy(busy),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model state: edge counter, pending frames, edges since the current frame was taken.
  int          cyc = 0;
  logic [7:0]  mq[$];
  int          svc = -1;
  logic [2:0]  m_addr = 3'd0;
  logic [4:0]  m_data = 5'd0;
  logic        m_ovr = 1'b0;
  logic        m_ferr = 1'b0;
  bit          push_v[int];
  logic [7:0]  push_b[int];
  bit          ferr_v[int];

  initial begin : model_proc
    bit         take;
    bit         drop;
    logic [7:0] b;
    forever begin
      @(posedge clk or negedge rst_n);
      if (clk) cyc++;
      if (!rst_n) begin
        mq.delete();
        svc = -1;
        m_addr = 3'd0;
        m_data = 5'd0;
        m_ovr = 1'b0;
        m_ferr = 1'b0;
      end else begin
        take = (svc == -1) && (mq.size() > 0);
        drop = 1'b0;
        if (take) begin
          b = mq.pop_front();
          m_addr = b[7:5];
          m_data = b[4:0];
        end
        if (push_v.exists(cyc)) begin
          if (mq.size() < D) mq.push_back(push_b[cyc]);
          else drop = 1'b1;
        end
        m_ovr  = drop | (m_ovr & ~err_clr);
        m_ferr = ferr_v.exists(cyc) | (m_ferr & ~err_clr);
        if (take) svc = 0;
        else if (svc >= 0) begin
          svc++;
          if (svc == S + 2 * H) svc = -1;
        end
      end
    end
  end

  initial begin : compare_proc
    logic [11:0] exp_v, act_v;
    logic        m_strobe, m_busy;
    forever begin
      @(negedge clk);
      m_strobe = (svc >= S) && (svc < S + H);
      m_busy   = (svc != -1) || (mq.size() != 0);
      exp_v = {m_strobe, m_addr, m_data, m_busy, m_ovr, m_ferr};
      act_v = {bus.wr_strobe, bus.wr_address, bus.wr_data, busy, overrun, frame_err};
      check($sformatf("outputs@%0d", cyc), 32'(act_v), 32'(exp_v));
    end
  end

  int run = 0;
  int last_len = 0;
  initial begin : strobe_len_mon
    forever begin
      @(negedge clk);
      if (bus.wr_strobe === 1'b1) run++;
      else if (run > 0) begin
        last_len = run;
        run = 0;
      end
    end
  end

  // SPI driver; it predicts the edge at which the DUT acts on each bit (3 edges later).
  int         bitcnt = 0;
  logic [7:0] sh = 8'd0;
  int         last_push = 0;

  task automatic spi_bit(input logic b, input bit clr_here);
    @(negedge clk);
    err_clr  = 1'b0;
    spi_sclk = 1'b0;
    spi_mosi = b;
    repeat (3) @(negedge clk);
    spi_sclk = 1'b1;
    if (ena) begin
      sh = {sh[6:0], b};
      bitcnt++;
      if (bitcnt == 8) begin
        push_v[cyc + 3] = 1'b1;
        push_b[cyc + 3] = sh;
        last_push = cyc + 3;
        bitcnt = 0;
      end
    end
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      err_clr = (i == 2) ? clr_here : 1'b0;
    end
  endtask

  task automatic send_bits(input logic [7:0] v, input int n, input bit clr_last);
    for (int i = 0; i < n; i++) spi_bit(v[7 - i], clr_last && (i == n - 1));
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk);
    err_clr  = 1'b0;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    if (bitcnt != 0) ferr_v[cyc + 3] = 1'b1;
    bitcnt = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] v);
    cs_low();
    send_bits(v, 8, 1'b0);
    cs_high();
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    repeat (5) @(negedge clk);
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_strobe(input int budget);
    int n;
    n = 0;
    while (bus.wr_strobe !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("strobe_timeout", 32'(bus.wr_strobe), 32'd1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t_push, rise, len, n;
    logic [7:0] stream [6];
    stream[0] = 8'h21; stream[1] = 8'h42; stream[2] = 8'h63;
    stream[3] = 8'h84; stream[4] = 8'hA5; stream[5] = 8'hC6;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_outputs", 32'({bus.wr_strobe, bus.wr_address, bus.wr_data, busy, overrun, frame_err}), 32'd0);

    // Single frame 0xA7: address 5, data 7, strobe 9 edges after push, 128 wide.
    send_frame(8'hA7);
    t_push = last_push;
    wait_strobe(100);
    rise = cyc;
    check("rise_latency", 32'(rise - t_push), 32'd9);
    len = 0;
    while (bus.wr_strobe === 1'b1 && len < 1000) begin
      @(negedge clk);
      len++;
    end
    check("strobe_len", 32'(len), 32'd128);
    check("a7_addr", 32'(bus.wr_address), 32'd5);
    check("a7_data", 32'(bus.wr_data), 32'd7);
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("busy_release", 32'(cyc - t_push), 32'd265);

    // Stream of six bytes: one in service, four buffered, the sixth is dropped.
    cs_low();
    for (int i = 0; i < 6; i++) send_bits(stream[i], 8, 1'b0);
    cs_high();
    check("overrun_set", 32'(overrun), 32'd1);
    pulse_clr();
    check("overrun_clr", 32'(overrun), 32'd0);
    wait_idle(3000);
    check("stream_last_addr", 32'(bus.wr_address), 32'd5);
    check("stream_last_data", 32'(bus.wr_data), 32'd5);

    // Overrun drop on the same edge as err_clr leaves the flag set.
    cs_low();
    for (int i = 0; i < 6; i++) send_bits(stream[i], 8, (i == 5));
    cs_high();
    check("overrun_vs_clr", 32'(overrun), 32'd1);
    pulse_clr();
    wait_idle(3000);

    // Partial frame then a good frame 0x1F.
    cs_low();
    send_bits(8'hB0, 5, 1'b0);
    cs_high();
    check("frame_err_set", 32'(frame_err), 32'd1);
    check("partial_no_busy", 32'(busy), 32'd0);
    send_frame(8'h1F);
    wait_idle(1000);
    check("1f_addr", 32'(bus.wr_address), 32'd0);
    check("1f_data", 32'(bus.wr_data), 32'd31);
    pulse_clr();
    check("frame_err_clr", 32'(frame_err), 32'd0);

    // Asynchronous reset during STROBE with a second frame buffered.
    cs_low();
    send_bits(8'h5A, 8, 1'b0);
    send_bits(8'h3C, 8, 1'b0);
    cs_high();
    wait_strobe(400);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_strobe", 32'(bus.wr_strobe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_fifo_empty", 32'(busy), 32'd0);
    send_frame(8'h66);
    wait_idle(1000);
    check("66_addr", 32'(bus.wr_address), 32'd3);
    check("66_data", 32'(bus.wr_data), 32'd6);

    // ena low mid-strobe: the strobe completes; a frame sent meanwhile is ignored.
    send_frame(8'h47);
    wait_strobe(100);
    @(negedge clk);
    ena = 1'b0;
    send_frame(8'h99);
    wait_idle(1000);
    check("ena_strobe_len", 32'(last_len), 32'd128);
    check("ena_addr", 32'(bus.wr_address), 32'd2);
    check("ena_data", 32'(bus.wr_data), 32'd7);
    check("ena_no_err", 32'({overrun, frame_err}), 32'd0);
    ena = 1'b1;
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
